hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage CPU. It decides per-cycle stage write enables, bubbles and flushes, and sits beside the forwarding unit.
- Handles three cases: load-use stalls (hazards forwarding cannot cover), taken-branch/jump flushes of IF/ID, and multi-cycle data-memory waits via a req/ack handshake.
- Includes a timeout-to-error state for a memory that never acknowledges.

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait freeze with timeout.
// Optional saturating stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             IDEX_memread,
   input  logic [4:0]       IDEX_rt,
   input  logic [4:0]       IFID_rs,
   input  logic [4:0]       IFID_rt,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IFID_flush,
   output logic             IDEX_write,
   output logic             IDEX_bubble,
   output logic             EXMEM_write,
   output logic             MEMWB_bubble,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_wait_cnt;

   logic w_run;
   logic w_wait;
   logic w_freeze;
   logic w_loaduse;
   logic w_branch;

   assign w_run    = (r_state == S_RUN);
   assign w_wait   = (r_state == S_WAIT);
   assign w_freeze = (w_run && dmem_req && !dmem_ack) || (w_wait && !dmem_ack);
   // rt==0 is the hardwired zero register, so a load targeting it never creates a dependency
   assign w_loaduse = w_run && !w_freeze && IDEX_memread && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));
   assign w_branch  = w_run && !w_freeze && !w_loaduse && branch_taken;

   always_comb begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IFID_flush   = 1'b0;
      IDEX_write   = 1'b0;
      IDEX_bubble  = 1'b0;
      EXMEM_write  = 1'b0;
      MEMWB_bubble = 1'b0;
      if (w_run || w_wait) begin
         if (w_freeze) begin
            MEMWB_bubble = 1'b1;
         end else if (w_loaduse) begin
            IDEX_write  = 1'b1;
            IDEX_bubble = 1'b1;
            EXMEM_write = 1'b1;
         end else begin
            PC_write    = 1'b1;
            IFID_write  = 1'b1;
            IDEX_write  = 1'b1;
            EXMEM_write = 1'b1;
            IFID_flush  = w_branch;
         end
      end
   end

   assign err_o = (r_state == S_ERR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) r_state <= S_RUN;
            end
            S_RUN: begin
               if (dmem_req && !dmem_ack) begin
                  r_state    <= S_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            S_WAIT: begin
               // an ack arriving on the last allowed cycle still completes normally
               if (dmem_ack) begin
                  r_state    <= S_RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == LP_WAIT_LAST) begin
                  r_state <= S_ERR;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: r_state <= S_ERR;
         endcase
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if ((w_freeze || w_loaduse) && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cycles_o = r_stall_cnt;
`else
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic,
// checked against a rule-level reference model of the controller.
module tb_hazard_ctrl;

   localparam int TO    = 4;
   localparam int CW    = 4;
   localparam int SAT   = (1 << CW) - 1;
   localparam int P_IDLE = 0;
   localparam int P_RUN  = 1;
   localparam int P_WAIT = 2;
   localparam int P_ERR  = 3;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic          IDEX_memread = 1'b0;
   logic [4:0]    IDEX_rt = '0;
   logic [4:0]    IFID_rs = '0;
   logic [4:0]    IFID_rt = '0;
   logic          branch_taken = 1'b0;
   logic          dmem_req = 1'b0;
   logic          dmem_ack = 1'b0;
   logic          PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble;
   logic          EXMEM_write, MEMWB_bubble, err_o;
   logic [CW-1:0] stall_cycles_o;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .IDEX_memread(IDEX_memread), .IDEX_rt(IDEX_rt), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
      .IDEX_write(IDEX_write), .IDEX_bubble(IDEX_bubble), .EXMEM_write(EXMEM_write),
      .MEMWB_bubble(MEMWB_bubble), .err_o(err_o), .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] ctrl;  // {PC, IFID_w, IFID_flush, IDEX_w, IDEX_bub, EXMEM_w, MEMWB_bub}
      logic       err;
      int         cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int   m_mode  = P_IDLE;
   int   m_wait  = 0;
   int   m_stall = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Outputs for one cycle are derived from the rule list, then the model advances.
   task automatic cyc(input bit chk, input bit rst, input bit start, input bit mr,
                      input int ex_rt, input int rs, input int rt, input bit br,
                      input bit req, input bit ack);
      bit   fz, lu, bg, act;
      exp_t e;
      rst_i = rst; start_i = start; IDEX_memread = mr;
      IDEX_rt = 5'(ex_rt); IFID_rs = 5'(rs); IFID_rt = 5'(rt);
      branch_taken = br; dmem_req = req; dmem_ack = ack;

      act = (m_mode == P_RUN) || (m_mode == P_WAIT);
      fz  = (m_mode == P_RUN && req && !ack) || (m_mode == P_WAIT && !ack);
      lu  = (m_mode == P_RUN) && !fz && mr && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
      bg  = (m_mode == P_RUN) && !fz && !lu && br;
      e.ctrl = {act && !fz && !lu, act && !fz && !lu, bg, act && !fz, lu, act && !fz, fz};
      e.err  = (m_mode == P_ERR);
`ifdef HAZARD_STALL_CNT_EN
      e.cnt = m_stall;
`else
      e.cnt = 0;
`endif
      if (chk) q.push_back(e);

      if (rst) begin
         m_mode = P_IDLE; m_wait = 0; m_stall = 0;
      end else begin
         if ((fz || lu) && m_stall < SAT) m_stall++;
         if (m_mode == P_IDLE) begin
            if (start) m_mode = P_RUN;
         end else if (m_mode == P_RUN) begin
            if (req && !ack) begin m_mode = P_WAIT; m_wait = 0; end
         end else if (m_mode == P_WAIT) begin
            if (ack) begin m_mode = P_RUN; m_wait = 0; end
            else if (m_wait == TO - 1) m_mode = P_ERR;
            else m_wait++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("ctrl", int'({PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble,
                             EXMEM_write, MEMWB_bubble}), int'(e.ctrl));
         check("err_o", int'(err_o), int'(e.err));
         check("stall_cycles", int'(stall_cycles_o), e.cnt);
      end
   end

   initial begin
      @(posedge clk);
      #1;
      cyc(0, 1,0, 0,0,0,0, 0, 0,0);
      cyc(1, 1,0, 0,0,0,0, 0, 0,0);
      cyc(1, 0,0, 0,0,0,0, 0, 0,0);
      cyc(1, 0,1, 0,0,0,0, 0, 0,0);
      cyc(1, 0,0, 0,0,0,0, 0, 0,0);
      // load-use, rt=0 no-hazard, match on rt field
      cyc(1, 0,0, 1,5,5,0, 0, 0,0);
      cyc(1, 0,0, 0,5,5,0, 0, 0,0);
      cyc(1, 0,0, 1,0,0,0, 0, 0,0);
      cyc(1, 0,0, 1,7,1,7, 0, 0,0);
      // branch alone, branch with load-use, start ignored in RUN
      cyc(1, 0,0, 0,0,0,0, 1, 0,0);
      cyc(1, 0,0, 1,5,5,0, 1, 0,0);
      cyc(1, 0,1, 0,0,0,0, 0, 0,0);
      // three-cycle memory wait with a branch pending during the freeze
      cyc(1, 0,0, 0,0,0,0, 1, 1,0);
      cyc(1, 0,0, 1,3,3,0, 1, 1,0);
      cyc(1, 0,0, 0,0,0,0, 0, 1,0);
      cyc(1, 0,0, 0,0,0,0, 0, 1,1);
      cyc(1, 0,0, 0,0,0,0, 1, 0,0);
      // single-cycle memory with load-use
      cyc(1, 0,0, 1,4,0,4, 0, 1,1);
      // timeout into ERR, then stuck until reset
      for (int i = 0; i < 5; i++) cyc(1, 0,0, 0,0,0,0, 0, 1,0);
      for (int i = 0; i < 3; i++) cyc(1, 0,1, 1,2,2,2, 1, 1,1);
      cyc(1, 1,0, 0,0,0,0, 0, 0,0);
      cyc(1, 0,1, 0,0,0,0, 0, 0,0);
      // reset in the middle of WAIT
      cyc(1, 0,0, 0,0,0,0, 0, 1,0);
      cyc(1, 0,0, 0,0,0,0, 0, 1,0);
      cyc(1, 1,0, 0,0,0,0, 0, 1,0);
      cyc(1, 0,0, 0,0,0,0, 0, 0,0);
      cyc(1, 0,1, 0,0,0,0, 0, 0,0);
      // ack on the final permitted WAIT cycle returns to RUN
      for (int i = 0; i < 4; i++) cyc(1, 0,0, 0,0,0,0, 0, 1,0);
      cyc(1, 0,0, 0,0,0,0, 0, 1,1);
      cyc(1, 0,0, 0,0,0,0, 1, 0,0);
      // long stall sequence drives the counter into saturation
      for (int i = 0; i < 20; i++) cyc(1, 0,0, 1,6,6,0, 0, 0,0);
      for (int i = 0; i < 3; i++) cyc(1, 0,0, 0,0,0,0, 0, 1,0);
      cyc(1, 0,0, 0,0,0,0, 0, 0,1);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cyc(1, ($urandom_range(59) == 0), $urandom_range(1),
             ($urandom_range(2) == 0), $urandom_range(3), $urandom_range(3), $urandom_range(3),
             ($urandom_range(3) == 0), ($urandom_range(2) == 0), ($urandom_range(4) < 2));
      end
      @(negedge clk);
      #1;
      check("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
